// File: rtl/pwm_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pwm_sched_pkg
// Brief    : Shared FSM encodings and command-record layout for the PWM
//            command scheduler.
// Revision : 1.0
// ============================================================================
package pwm_sched_pkg;

    localparam int c_ch_w      = 8;
    localparam int c_duty_w    = 8;
    localparam int c_dessert_w = 16;
    localparam int c_pulse_w   = 8;
    localparam int c_hdr_w     = c_ch_w + c_duty_w + c_dessert_w + c_pulse_w;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_POP     = 3'd1,
        ST_WAIT_CH = 3'd2,
        ST_LOAD    = 3'd3,
        ST_START   = 3'd4
    } sched_state_t;

    // Record is packed as {ch, duty, dessert, pulse_num, pat}, MSB first.
    function automatic int cmd_rec_width(input int pat_w);
        return c_hdr_w + pat_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_cmd_fifo
// Brief    : Single-clock command queue with registered read data and
//            full/empty/level status. DEPTH must be a power of two.
// Revision : 1.0
// ============================================================================
module sync_cmd_fifo #(
    parameter int WIDTH = 72,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_wr_en,
    input  logic [WIDTH-1:0]        i_wr_data,
    input  logic                    i_rd_en,
    output logic [WIDTH-1:0]        o_rd_data,
    output logic                    o_full,
    output logic                    o_empty,
    output logic [$clog2(DEPTH):0]  o_level
);

    localparam int              c_aw    = $clog2(DEPTH);
    localparam logic [c_aw:0]   c_depth = (c_aw + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wptr;
    logic [c_aw-1:0]  r_rptr;
    logic [c_aw:0]    r_level;
    logic [WIDTH-1:0] r_rd_data;
    logic             w_push;
    logic             w_pop;

    assign o_full    = (r_level == c_depth);
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;
    assign o_rd_data = r_rd_data;
    assign w_push    = i_wr_en && !o_full;
    assign w_pop     = i_rd_en && !o_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_level   <= '0;
            r_rd_data <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr    <= r_rptr + 1'b1;
                r_rd_data <= r_mem[r_rptr];
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/pwm_cmd_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : pwm_cmd_scheduler
// Brief    : Queues decoded UART commands and dispatches them in order onto a
//            shared PWM channel configuration bus with load/start strobes.
// Revision : 1.0
// ============================================================================
module pwm_cmd_scheduler
    import pwm_sched_pkg::*;
#(
    parameter int          _NUM_CHANNELS = 3,
    parameter int          _PAT_WIDTH    = 32,
    parameter int          _FIFO_DEPTH   = 4,
    parameter logic [15:0] _WAIT_TIMEOUT = 16'd50000
) (
    input  logic                           clk_50M,
    input  logic                           rst_n,
    input  logic                           cmd_valid,
    input  logic [7:0]                     cmd_ch,
    input  logic [7:0]                     cmd_duty,
    input  logic [15:0]                    cmd_dessert,
    input  logic [7:0]                     cmd_pulse_num,
    input  logic [_PAT_WIDTH-1:0]          cmd_pat,
    output logic                           cmd_ready,
    input  logic [_NUM_CHANNELS-1:0]       ch_busy,
    input  logic [_NUM_CHANNELS-1:0]       ch_valid,
    output logic [7:0]                     ch_duty,
    output logic [15:0]                    ch_dessert,
    output logic [7:0]                     ch_pulse_num,
    output logic [_PAT_WIDTH-1:0]          ch_pat,
    output logic [_NUM_CHANNELS-1:0]       ch_load,
    output logic [_NUM_CHANNELS-1:0]       ch_en,
    output logic                           sched_busy,
    output logic [$clog2(_FIFO_DEPTH):0]   fifo_level,
    output logic [7:0]                     drop_cnt,
    output logic                           err_pulse
);

    localparam int                       c_rec_w       = cmd_rec_width(_PAT_WIDTH);
    localparam int                       c_pulse_lsb   = _PAT_WIDTH;
    localparam int                       c_dessert_lsb = c_pulse_lsb + c_pulse_w;
    localparam int                       c_duty_lsb    = c_dessert_lsb + c_dessert_w;
    localparam int                       c_ch_lsb      = c_duty_lsb + c_duty_w;
    localparam logic [7:0]               c_num_ch      = 8'(_NUM_CHANNELS);
    localparam logic [15:0]              c_wait_last   = _WAIT_TIMEOUT - 16'd1;
    localparam logic [_NUM_CHANNELS-1:0] c_ch_one      = {{(_NUM_CHANNELS-1){1'b0}}, 1'b1};

    sched_state_t              r_state;
    logic [15:0]               r_wait;
    logic [_NUM_CHANNELS-1:0]  r_ch_load;
    logic [_NUM_CHANNELS-1:0]  r_ch_en;
    logic [7:0]                r_ch_duty;
    logic [15:0]               r_ch_dessert;
    logic [7:0]                r_ch_pulse_num;
    logic [_PAT_WIDTH-1:0]     r_ch_pat;
    logic [7:0]                r_drop_cnt;
    logic                      r_err_pulse;

    logic                      w_full;
    logic                      w_empty;
    logic                      w_ch_ok;
    logic                      w_enq;
    logic                      w_enq_drop;
    logic                      w_rd_en;
    logic [c_rec_w-1:0]        w_rec_in;
    logic [c_rec_w-1:0]        w_work;
    logic [7:0]                w_work_ch;
    logic [_NUM_CHANNELS-1:0]  w_tgt_onehot;
    logic                      w_tgt_busy;
    logic                      w_timeout_fire;
    logic [8:0]                w_drop_sum;
    logic                      w_unused_ch_valid;

    assign w_ch_ok    = (cmd_ch < c_num_ch);
    assign w_enq      = cmd_valid && w_ch_ok && !w_full;
    assign w_enq_drop = cmd_valid && (w_full || !w_ch_ok);
    assign w_rd_en    = (r_state == ST_POP);
    assign w_rec_in   = {cmd_ch, cmd_duty, cmd_dessert, cmd_pulse_num, cmd_pat};

    // Done status is observed only; it never steers dispatch.
    assign w_unused_ch_valid = ^ch_valid;

    sync_cmd_fifo #(
        .WIDTH (c_rec_w),
        .DEPTH (_FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk_50M),
        .rst_n     (rst_n),
        .i_wr_en   (w_enq),
        .i_wr_data (w_rec_in),
        .i_rd_en   (w_rd_en),
        .o_rd_data (w_work),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_level   (fifo_level)
    );

    // The FIFO's registered read port holds the popped head for the whole dispatch.
    assign w_work_ch      = w_work[c_ch_lsb +: c_ch_w];
    assign w_tgt_onehot   = c_ch_one << w_work_ch;
    assign w_tgt_busy     = |(ch_busy & w_tgt_onehot);
    assign w_timeout_fire = (r_state == ST_WAIT_CH) && w_tgt_busy && (r_wait == c_wait_last);

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_wait         <= '0;
            r_ch_load      <= '0;
            r_ch_en        <= '0;
            r_ch_duty      <= '0;
            r_ch_dessert   <= '0;
            r_ch_pulse_num <= '0;
            r_ch_pat       <= '0;
        end else begin
            r_ch_load <= '0;
            r_ch_en   <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        r_state <= ST_POP;
                    end
                end
                ST_POP: begin
                    r_wait  <= '0;
                    r_state <= ST_WAIT_CH;
                end
                ST_WAIT_CH: begin
                    if (!w_tgt_busy) begin
                        r_ch_load      <= w_tgt_onehot;
                        r_ch_duty      <= w_work[c_duty_lsb +: c_duty_w];
                        r_ch_dessert   <= w_work[c_dessert_lsb +: c_dessert_w];
                        r_ch_pulse_num <= w_work[c_pulse_lsb +: c_pulse_w];
                        r_ch_pat       <= w_work[_PAT_WIDTH-1:0];
                        r_state        <= ST_LOAD;
                    end else if (w_timeout_fire) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_wait <= r_wait + 16'd1;
                    end
                end
                ST_LOAD: begin
                    r_ch_en <= w_tgt_onehot;
                    r_state <= ST_START;
                end
                ST_START: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // An enqueue drop and a timeout can coincide, so the counter may step by two.
    assign w_drop_sum = {1'b0, r_drop_cnt} + {8'd0, w_enq_drop} + {8'd0, w_timeout_fire};

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_cnt  <= '0;
            r_err_pulse <= 1'b0;
        end else begin
            r_drop_cnt  <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
            r_err_pulse <= w_enq_drop || w_timeout_fire;
        end
    end

    assign cmd_ready    = !w_full;
    assign sched_busy   = (r_state != ST_IDLE);
    assign ch_load      = r_ch_load;
    assign ch_en        = r_ch_en;
    assign ch_duty      = r_ch_duty;
    assign ch_dessert   = r_ch_dessert;
    assign ch_pulse_num = r_ch_pulse_num;
    assign ch_pat       = r_ch_pat;
    assign drop_cnt     = r_drop_cnt;
    assign err_pulse    = r_err_pulse;

endmodule
`default_nettype wire

// File: tb/tb_pwm_cmd_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_cmd_scheduler
// Brief    : Self-checking bench for pwm_cmd_scheduler; a second instance with
//            a short wait timeout covers the timeout behaviour.
// Revision : 1.0
// ============================================================================
module tb_pwm_cmd_scheduler;

    localparam int NCH   = 3;
    localparam int PW    = 32;
    localparam int DEPTH = 4;
    localparam int TO    = 10;

    logic          clk_50M = 1'b0;
    logic          rst_n = 1'b1;
    logic          cmd_valid = 1'b0;
    logic [7:0]    cmd_ch = '0;
    logic [7:0]    cmd_duty = '0;
    logic [15:0]   cmd_dessert = '0;
    logic [7:0]    cmd_pulse_num = '0;
    logic [PW-1:0] cmd_pat = '0;
    logic [NCH-1:0] ch_busy = '0;
    logic [NCH-1:0] ch_valid = '0;

    logic           cmd_ready, sched_busy, err_pulse;
    logic [7:0]     ch_duty, ch_pulse_num, drop_cnt;
    logic [15:0]    ch_dessert;
    logic [PW-1:0]  ch_pat;
    logic [NCH-1:0] ch_load, ch_en;
    logic [2:0]     fifo_level;

    logic           t_cmd_ready, t_sched_busy, t_err_pulse;
    logic [7:0]     t_ch_duty, t_ch_pulse_num, t_drop_cnt;
    logic [15:0]    t_ch_dessert;
    logic [PW-1:0]  t_ch_pat;
    logic [NCH-1:0] t_ch_load, t_ch_en;
    logic [2:0]     t_fifo_level;

    int vectors = 0;
    int miscompares = 0;

    pwm_cmd_scheduler #(
        ._NUM_CHANNELS (NCH), ._PAT_WIDTH (PW), ._FIFO_DEPTH (DEPTH), ._WAIT_TIMEOUT (16'd50000)
    ) dut (
        .clk_50M (clk_50M), .rst_n (rst_n), .cmd_valid (cmd_valid), .cmd_ch (cmd_ch),
        .cmd_duty (cmd_duty), .cmd_dessert (cmd_dessert), .cmd_pulse_num (cmd_pulse_num),
        .cmd_pat (cmd_pat), .cmd_ready (cmd_ready), .ch_busy (ch_busy), .ch_valid (ch_valid),
        .ch_duty (ch_duty), .ch_dessert (ch_dessert), .ch_pulse_num (ch_pulse_num),
        .ch_pat (ch_pat), .ch_load (ch_load), .ch_en (ch_en), .sched_busy (sched_busy),
        .fifo_level (fifo_level), .drop_cnt (drop_cnt), .err_pulse (err_pulse)
    );

    pwm_cmd_scheduler #(
        ._NUM_CHANNELS (NCH), ._PAT_WIDTH (PW), ._FIFO_DEPTH (DEPTH), ._WAIT_TIMEOUT (16'(TO))
    ) dut_to (
        .clk_50M (clk_50M), .rst_n (rst_n), .cmd_valid (cmd_valid), .cmd_ch (cmd_ch),
        .cmd_duty (cmd_duty), .cmd_dessert (cmd_dessert), .cmd_pulse_num (cmd_pulse_num),
        .cmd_pat (cmd_pat), .cmd_ready (t_cmd_ready), .ch_busy (ch_busy), .ch_valid (ch_valid),
        .ch_duty (t_ch_duty), .ch_dessert (t_ch_dessert), .ch_pulse_num (t_ch_pulse_num),
        .ch_pat (t_ch_pat), .ch_load (t_ch_load), .ch_en (t_ch_en), .sched_busy (t_sched_busy),
        .fifo_level (t_fifo_level), .drop_cnt (t_drop_cnt), .err_pulse (t_err_pulse)
    );

    always #10 clk_50M = ~clk_50M;

    task automatic step();
        @(posedge clk_50M);
        #1;
    endtask

    task automatic idle_inputs();
        cmd_valid     = 1'b0;
        cmd_ch        = '0;
        cmd_duty      = '0;
        cmd_dessert   = '0;
        cmd_pulse_num = '0;
        cmd_pat       = '0;
        ch_busy       = '0;
        ch_valid      = '0;
    endtask

    task automatic do_reset();
        step();
        rst_n = 1'b0;
        idle_inputs();
        repeat (3) step();
        rst_n = 1'b1;
    endtask

    task automatic drive_cmd(input logic [7:0] ch);
        cmd_valid     = 1'b1;
        cmd_ch        = ch;
        cmd_duty      = 8'($urandom);
        cmd_dessert   = 16'($urandom);
        cmd_pulse_num = 8'($urandom);
        cmd_pat       = $urandom;
    endtask

    task automatic test_reset();
        step();
        rst_n = 1'b0;
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            if (k > 0) step();
            #2;
            vectors++;
            if ({cmd_ready, sched_busy, err_pulse} !== 3'b100) begin
                miscompares++;
                $display("FAIL reset_flags: got ready/busy/err=%b want 100", {cmd_ready, sched_busy, err_pulse});
            end
            vectors++;
            if ({ch_load, ch_en} !== '0) begin
                miscompares++;
                $display("FAIL reset_strobes: got load=%b en=%b want 0", ch_load, ch_en);
            end
            vectors++;
            if (fifo_level !== 3'd0 || drop_cnt !== 8'd0) begin
                miscompares++;
                $display("FAIL reset_counts: got level=%0d drop=%0d want 0", fifo_level, drop_cnt);
            end
            vectors++;
            if ({ch_duty, ch_dessert, ch_pulse_num, ch_pat} !== 64'd0) begin
                miscompares++;
                $display("FAIL reset_bus: got %h want 0", {ch_duty, ch_dessert, ch_pulse_num, ch_pat});
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        logic [31:0]    pat;
        logic [NCH-1:0] exp_ld, exp_en;
        logic           exp_busy;
        pat = $urandom;
        do_reset();
        for (int k = 0; k < 9; k++) begin
            step();
            if (k == 0) begin
                cmd_valid = 1'b1; cmd_ch = 8'd1; cmd_duty = 8'h10;
                cmd_dessert = 16'd100; cmd_pulse_num = 8'd3; cmd_pat = pat;
            end else begin
                cmd_valid = 1'b0;
            end
            @(negedge clk_50M);
            exp_ld   = (k == 4) ? 3'b010 : 3'b000;
            exp_en   = (k == 5) ? 3'b010 : 3'b000;
            exp_busy = (k >= 2 && k <= 5);
            vectors++;
            if (ch_load !== exp_ld) begin
                miscompares++;
                $display("FAIL single_load c%0d: got %b want %b", k, ch_load, exp_ld);
            end
            vectors++;
            if (ch_en !== exp_en) begin
                miscompares++;
                $display("FAIL single_en c%0d: got %b want %b", k, ch_en, exp_en);
            end
            vectors++;
            if (sched_busy !== exp_busy) begin
                miscompares++;
                $display("FAIL single_busy c%0d: got %b want %b", k, sched_busy, exp_busy);
            end
            if (k >= 4) begin
                vectors++;
                if ({ch_duty, ch_dessert, ch_pulse_num, ch_pat} !== {8'h10, 16'd100, 8'd3, pat}) begin
                    miscompares++;
                    $display("FAIL single_bus c%0d: got %h want %h", k,
                             {ch_duty, ch_dessert, ch_pulse_num, ch_pat}, {8'h10, 16'd100, 8'd3, pat});
                end
            end
            if (k == 1) begin
                vectors++;
                if (fifo_level !== 3'd1) begin
                    miscompares++;
                    $display("FAIL single_level: got %0d want 1", fifo_level);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]     chs [3];
        logic [7:0]     duties [3];
        int             en_cyc [$];
        logic [NCH-1:0] en_val [$];
        logic [7:0]     en_duty [$];
        int             exp_cyc [3];
        logic [NCH-1:0] exp_val [3];
        int             release_cyc;
        chs[0] = 8'd0; chs[1] = 8'd2; chs[2] = 8'd0;
        release_cyc = 5 + 1 + 20;
        exp_cyc[0] = 5;  exp_cyc[1] = 10; exp_cyc[2] = release_cyc + 2;
        exp_val[0] = 3'b001; exp_val[1] = 3'b100; exp_val[2] = 3'b001;
        do_reset();
        for (int k = 0; k < 40; k++) begin
            step();
            if (k < 3) begin
                drive_cmd(chs[k]);
                duties[k] = cmd_duty;
            end else begin
                cmd_valid = 1'b0;
            end
            ch_busy = (k > 5 && k < release_cyc) ? 3'b001 : 3'b000;
            @(negedge clk_50M);
            if (ch_en !== 3'b000) begin
                en_cyc.push_back(k);
                en_val.push_back(ch_en);
                en_duty.push_back(ch_duty);
            end
        end
        vectors++;
        if (en_cyc.size() != 3) begin
            miscompares++;
            $display("FAIL b2b_count: got %0d starts want 3", en_cyc.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                vectors++;
                if (en_cyc[i] != exp_cyc[i] || en_val[i] !== exp_val[i] || en_duty[i] !== duties[i]) begin
                    miscompares++;
                    $display("FAIL b2b_start%0d: got c%0d en=%b duty=%h want c%0d en=%b duty=%h", i,
                             en_cyc[i], en_val[i], en_duty[i], exp_cyc[i], exp_val[i], duties[i]);
                end
            end
        end
    endtask

    task automatic test_overflow();
        int errs;
        errs = 0;
        do_reset();
        for (int k = 0; k < 12; k++) begin
            step();
            ch_busy = 3'b001;
            if (k < 6) drive_cmd(8'd0);
            else cmd_valid = 1'b0;
            @(negedge clk_50M);
            if (err_pulse === 1'b1) errs++;
            if (k == 4 || k == 5) begin
                vectors++;
                if (cmd_ready !== (k == 4)) begin
                    miscompares++;
                    $display("FAIL ovf_ready c%0d: got %b want %b", k, cmd_ready, (k == 4));
                end
            end
            vectors++;
            if (ch_en !== 3'b000) begin
                miscompares++;
                $display("FAIL ovf_en c%0d: got %b want 000", k, ch_en);
            end
        end
        vectors++;
        if (errs != 1 || drop_cnt !== 8'd1) begin
            miscompares++;
            $display("FAIL ovf_drop: got err_pulses=%0d drop=%0d want 1/1", errs, drop_cnt);
        end
        vectors++;
        if (fifo_level !== 3'd4 || cmd_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_level: got level=%0d ready=%b want 4/0", fifo_level, cmd_ready);
        end
    endtask

    task automatic test_bad_channel();
        do_reset();
        for (int k = 0; k < 10; k++) begin
            step();
            ch_busy = 3'b111;
            if (k == 0 || k == 1) drive_cmd(8'd0);
            else if (k == 4) drive_cmd(8'd7);
            else if (k == 6) drive_cmd(8'd3);
            else cmd_valid = 1'b0;
            @(negedge clk_50M);
            if (k == 3 || k == 5 || k == 7) begin
                vectors++;
                if (fifo_level !== 3'd1) begin
                    miscompares++;
                    $display("FAIL bad_level c%0d: got %0d want 1", k, fifo_level);
                end
            end
            if (k >= 5 && k <= 8) begin
                vectors++;
                if (err_pulse !== (k == 5 || k == 7)) begin
                    miscompares++;
                    $display("FAIL bad_err c%0d: got %b want %b", k, err_pulse, (k == 5 || k == 7));
                end
                vectors++;
                if (drop_cnt !== ((k >= 7) ? 8'd2 : 8'd1)) begin
                    miscompares++;
                    $display("FAIL bad_drop c%0d: got %0d want %0d", k, drop_cnt, (k >= 7) ? 2 : 1);
                end
            end
        end
    endtask

    task automatic test_timeout();
        int  wait_first, wait_last;
        logic exp_busy;
        wait_first = 3;
        wait_last  = wait_first + TO - 1;
        do_reset();
        for (int k = 0; k < 18; k++) begin
            step();
            ch_busy = 3'b010;
            if (k == 0) drive_cmd(8'd1);
            else cmd_valid = 1'b0;
            @(negedge clk_50M);
            exp_busy = (k >= 2 && k <= wait_last);
            vectors++;
            if (t_sched_busy !== exp_busy || t_err_pulse !== (k == wait_last + 1)) begin
                miscompares++;
                $display("FAIL to_state c%0d: got busy=%b err=%b want %b/%b", k, t_sched_busy,
                         t_err_pulse, exp_busy, (k == wait_last + 1));
            end
            vectors++;
            if ({t_ch_load, t_ch_en} !== '0) begin
                miscompares++;
                $display("FAIL to_strobe c%0d: got load=%b en=%b want 0", k, t_ch_load, t_ch_en);
            end
        end
        vectors++;
        if (t_drop_cnt !== 8'd1) begin
            miscompares++;
            $display("FAIL to_drop: got %0d want 1", t_drop_cnt);
        end
        // Channel frees on the last allowed wait cycle: must dispatch, not drop.
        do_reset();
        for (int k = 0; k < 18; k++) begin
            step();
            ch_busy = (k < wait_last) ? 3'b010 : 3'b000;
            if (k == 0) drive_cmd(8'd1);
            else cmd_valid = 1'b0;
            @(negedge clk_50M);
            vectors++;
            if (t_ch_en !== ((k == wait_last + 2) ? 3'b010 : 3'b000)) begin
                miscompares++;
                $display("FAIL to_edge_en c%0d: got %b want %b", k, t_ch_en,
                         (k == wait_last + 2) ? 3'b010 : 3'b000);
            end
        end
        vectors++;
        if (t_drop_cnt !== 8'd0) begin
            miscompares++;
            $display("FAIL to_edge_drop: got %0d want 0", t_drop_cnt);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int k = 0; k < 5; k++) begin
            step();
            ch_busy = 3'b111;
            if (k < 3) drive_cmd(8'(k % 3));
            else cmd_valid = 1'b0;
        end
        @(negedge clk_50M);
        vectors++;
        if (fifo_level !== 3'd2 || sched_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL rmid_pre: got level=%0d busy=%b want 2/1", fifo_level, sched_busy);
        end
        step();
        rst_n = 1'b0;
        #2;
        vectors++;
        if (fifo_level !== 3'd0 || sched_busy !== 1'b0 || {ch_load, ch_en} !== '0) begin
            miscompares++;
            $display("FAIL rmid_in: got level=%0d busy=%b load=%b en=%b want 0", fifo_level,
                     sched_busy, ch_load, ch_en);
        end
        step();
        step();
        rst_n = 1'b1;
        ch_busy = 3'b000;
        for (int k = 0; k < 12; k++) begin
            step();
            @(negedge clk_50M);
            vectors++;
            if ({ch_load, ch_en} !== '0 || sched_busy !== 1'b0 || fifo_level !== 3'd0) begin
                miscompares++;
                $display("FAIL rmid_post c%0d: got load=%b en=%b busy=%b level=%0d want 0", k,
                         ch_load, ch_en, sched_busy, fifo_level);
            end
        end
    endtask

    task automatic test_random();
        localparam int NC = 40;
        localparam int NMAX = 512;
        logic [NCH-1:0] exp_ld [NMAX];
        logic [NCH-1:0] exp_en [NMAX];
        logic [63:0]    exp_bus [NMAX];
        logic           exp_err [NMAX];
        logic [7:0]     exp_drop [NMAX];
        logic           s_v [NMAX];
        logic [7:0]     s_ch [NMAX];
        logic [63:0]    s_f [NMAX];
        logic [63:0]    cur;
        int             t, d, last;
        for (int c = 0; c < NMAX; c++) begin
            exp_ld[c] = '0; exp_en[c] = '0; exp_bus[c] = '0; exp_err[c] = 1'b0;
            s_v[c] = 1'b0; s_ch[c] = '0; s_f[c] = '0;
        end
        // Spaced strobes never build a queue, so every valid command sees minimum latency.
        t = 2;
        for (int i = 0; i < NC; i++) begin
            s_v[t]  = 1'b1;
            s_ch[t] = 8'($urandom_range(0, 4));
            s_f[t]  = {$urandom, $urandom};
            if (s_ch[t] < NCH) begin
                exp_ld[t + 4]  = 3'b001 << s_ch[t];
                exp_en[t + 5]  = 3'b001 << s_ch[t];
                exp_bus[t + 4] = s_f[t];
            end else begin
                exp_err[t + 1] = 1'b1;
            end
            t += $urandom_range(5, 8);
        end
        last = t + 8;
        cur = '0;
        d = 0;
        for (int c = 0; c < last; c++) begin
            if (exp_ld[c] != '0) cur = exp_bus[c];
            exp_bus[c] = cur;
            if (exp_err[c]) d = (d < 255) ? d + 1 : 255;
            exp_drop[c] = 8'(d);
        end
        do_reset();
        for (int c = 0; c < last; c++) begin
            step();
            cmd_valid = s_v[c];
            if (s_v[c]) begin
                cmd_ch = s_ch[c];
                {cmd_duty, cmd_dessert, cmd_pulse_num, cmd_pat} = s_f[c];
            end
            ch_busy  = '0;
            ch_valid = 3'($urandom);
            @(negedge clk_50M);
            vectors++;
            if (ch_load !== exp_ld[c] || ch_en !== exp_en[c]) begin
                miscompares++;
                $display("FAIL rnd_strobe c%0d: got load=%b en=%b want %b/%b", c, ch_load, ch_en,
                         exp_ld[c], exp_en[c]);
            end
            vectors++;
            if ({ch_duty, ch_dessert, ch_pulse_num, ch_pat} !== exp_bus[c]) begin
                miscompares++;
                $display("FAIL rnd_bus c%0d: got %h want %h", c,
                         {ch_duty, ch_dessert, ch_pulse_num, ch_pat}, exp_bus[c]);
            end
            vectors++;
            if (err_pulse !== exp_err[c] || drop_cnt !== exp_drop[c]) begin
                miscompares++;
                $display("FAIL rnd_drop c%0d: got err=%b drop=%0d want %b/%0d", c, err_pulse,
                         drop_cnt, exp_err[c], exp_drop[c]);
            end
        end
    endtask

    task automatic test_saturation();
        int exp_d;
        do_reset();
        for (int k = 0; k < 270; k++) begin
            step();
            if (k < 262) drive_cmd(8'd200);
            else cmd_valid = 1'b0;
            @(negedge clk_50M);
            exp_d = (k < 255) ? k : 255;
            vectors++;
            if (drop_cnt !== 8'(exp_d) || err_pulse !== (k >= 1 && k <= 262) || fifo_level !== 3'd0) begin
                miscompares++;
                $display("FAIL sat c%0d: got drop=%0d err=%b level=%0d want %0d/%b/0", k, drop_cnt,
                         err_pulse, fifo_level, exp_d, (k >= 1 && k <= 262));
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_bad_channel();
        test_timeout();
        test_reset_mid();
        test_random();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
